// File: rtl/kd_tree_query_scheduler.sv
// kd_tree_query_scheduler: runs the internal_node_tree datapath in two phases.
//   LOAD  - opens the aggregator path until NUM_NODES node words have landed.
//   QUERY - issues patches to the tree one per cycle, tags each with a qid and
//           collects leaf indices in a credit-protected result FIFO.
// Optional macro LATENCY_CHECK_EN adds an issue-strobe delay line and a sticky
// lat_err output flagging any tree_leaf_valid that disagrees with it.
module kd_tree_query_scheduler #(
  parameter int NUM_NODES     = 63,
  parameter int PATCH_WIDTH   = 55,
  parameter int ADDRESS_WIDTH = 8,
  parameter int TREE_LATENCY  = 6,
  parameter int FIFO_DEPTH    = 8,
  parameter int QID_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              num_queries,
  output logic                     agg_full_n,
  input  logic                     node_enq,
  output logic                     tree_fsm_enable,
  input  logic                     patch_valid,
  output logic                     patch_ready,
  input  logic [PATCH_WIDTH-1:0]   patch_data,
  output logic                     tree_patch_en,
  output logic [PATCH_WIDTH-1:0]   tree_patch_in,
  input  logic [ADDRESS_WIDTH-1:0] tree_leaf_index,
  input  logic                     tree_leaf_valid,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [ADDRESS_WIDTH-1:0] result_index,
  output logic [QID_WIDTH-1:0]     result_qid,
  output logic                     busy,
  output logic                     done,
`ifdef LATENCY_CHECK_EN
  output logic                     lat_err,
`endif
  output logic                     proto_err
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int NCW = $clog2(NUM_NODES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_QUERY, S_DRAIN} state_t;

  typedef struct packed {
    logic [QID_WIDTH-1:0]     qid;
    logic [ADDRESS_WIDTH-1:0] idx;
  } res_t;

  state_t                 state_q, state_d;
  logic [15:0]            nq_q, nq_d;
  logic [NCW-1:0]         node_cnt_q, node_cnt_d;
  logic [15:0]            issue_cnt_q, issue_cnt_d;
  logic [QID_WIDTH-1:0]   qid_q, qid_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [QID_WIDTH-1:0]   tag_mem_q [FIFO_DEPTH];
  logic [QID_WIDTH-1:0]   tag_mem_d [FIFO_DEPTH];
  logic [PW-1:0]          tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  res_t                   res_mem_q [FIFO_DEPTH];
  res_t                   res_mem_d [FIFO_DEPTH];
  logic [PW-1:0]          res_wp_q, res_wp_d, res_rp_q, res_rp_d;
  logic [CW-1:0]          res_cnt_q, res_cnt_d;
  logic                   issue_en_q, issue_en_d;
  logic [PATCH_WIDTH-1:0] issue_data_q, issue_data_d;
  logic                   done_q, done_d;
  logic                   proto_err_q, proto_err_d;
  logic                   agg_open_q, agg_open_d;
  logic                   busy_q, busy_d;

  logic ready_c, accept, leaf_ok, res_pop;

`ifdef LATENCY_CHECK_EN
  logic [TREE_LATENCY:1] vld_pipe_q, vld_pipe_d;
  logic                  lat_err_q, lat_err_d;
`endif

  // Credit check: accepted-but-unreturned queries plus queued results never exceed the FIFO.
  always_comb begin
    ready_c = (state_q == S_QUERY) && (issue_cnt_q < nq_q) &&
              (({1'b0, inflight_q} + {1'b0, res_cnt_q}) < (CW + 1)'(FIFO_DEPTH));
    accept  = ready_c && patch_valid;
    leaf_ok = tree_leaf_valid && (inflight_q != '0);
    res_pop = (res_cnt_q != '0) && result_ready;
  end

  // Next-state for FSM, counters, tag FIFO, result FIFO and registered outputs.
  always_comb begin
    state_d      = state_q;
    nq_d         = nq_q;
    node_cnt_d   = node_cnt_q;
    issue_cnt_d  = issue_cnt_q;
    qid_d        = qid_q;
    done_d       = 1'b0;
    tag_mem_d    = tag_mem_q;
    tag_wp_d     = tag_wp_q;
    tag_rp_d     = tag_rp_q;
    res_mem_d    = res_mem_q;
    res_wp_d     = res_wp_q;
    res_rp_d     = res_rp_q;
    issue_en_d   = accept;
    issue_data_d = accept ? patch_data : issue_data_q;
    proto_err_d  = proto_err_q | (tree_leaf_valid && (inflight_q == '0));
    inflight_d   = inflight_q + CW'(accept) - CW'(leaf_ok);
    res_cnt_d    = res_cnt_q + CW'(leaf_ok) - CW'(res_pop);

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_LOAD;
        nq_d        = num_queries;
        node_cnt_d  = '0;
        issue_cnt_d = '0;
        qid_d       = '0;
      end
      S_LOAD: if (node_enq) begin
        node_cnt_d = node_cnt_q + NCW'(1);
        if (node_cnt_q == NCW'(NUM_NODES - 1))
          state_d = (nq_q == '0) ? S_DRAIN : S_QUERY;
      end
      S_QUERY: if (accept) begin
        issue_cnt_d = issue_cnt_q + 16'd1;
        qid_d       = qid_q + QID_WIDTH'(1);
        if (issue_cnt_q + 16'd1 == nq_q) state_d = S_DRAIN;
      end
      S_DRAIN: if ((inflight_q == '0) && (res_cnt_q == '0)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Tag FIFO mirrors inflight, so it is never empty when leaf_ok is set.
    if (accept) begin
      tag_mem_d[tag_wp_q] = qid_q;
      tag_wp_d            = tag_wp_q + PW'(1);
    end
    if (leaf_ok) begin
      tag_rp_d            = tag_rp_q + PW'(1);
      res_mem_d[res_wp_q] = '{qid: tag_mem_q[tag_rp_q], idx: tree_leaf_index};
      res_wp_d            = res_wp_q + PW'(1);
    end
    if (res_pop) res_rp_d = res_rp_q + PW'(1);

    agg_open_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
  end

`ifdef LATENCY_CHECK_EN
  // Delay line of issue strobes; its last tap predicts tree_leaf_valid.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[1] = issue_en_q;
    for (int k = 2; k <= TREE_LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    lat_err_d = lat_err_q | (tree_leaf_valid != vld_pipe_q[TREE_LATENCY]);
  end

  // Latency checker state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      lat_err_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      lat_err_q  <= lat_err_d;
    end
  end

  assign lat_err = lat_err_q;
`endif

  // All scheduler state; reset drops in-flight work and empties both FIFOs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      nq_q         <= '0;
      node_cnt_q   <= '0;
      issue_cnt_q  <= '0;
      qid_q        <= '0;
      inflight_q   <= '0;
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      res_wp_q     <= '0;
      res_rp_q     <= '0;
      res_cnt_q    <= '0;
      issue_en_q   <= 1'b0;
      issue_data_q <= '0;
      done_q       <= 1'b0;
      proto_err_q  <= 1'b0;
      agg_open_q   <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
        res_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      nq_q         <= nq_d;
      node_cnt_q   <= node_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
      qid_q        <= qid_d;
      inflight_q   <= inflight_d;
      tag_wp_q     <= tag_wp_d;
      tag_rp_q     <= tag_rp_d;
      res_wp_q     <= res_wp_d;
      res_rp_q     <= res_rp_d;
      res_cnt_q    <= res_cnt_d;
      issue_en_q   <= issue_en_d;
      issue_data_q <= issue_data_d;
      done_q       <= done_d;
      proto_err_q  <= proto_err_d;
      agg_open_q   <= agg_open_d;
      busy_q       <= busy_d;
      tag_mem_q    <= tag_mem_d;
      res_mem_q    <= res_mem_d;
    end
  end

  assign agg_full_n      = agg_open_q;
  assign tree_fsm_enable = agg_open_q;
  assign patch_ready     = ready_c;
  assign tree_patch_en   = issue_en_q;
  assign tree_patch_in   = issue_data_q;
  assign result_valid    = (res_cnt_q != '0);
  assign result_index    = res_mem_q[res_rp_q].idx;
  assign result_qid      = res_mem_q[res_rp_q].qid;
  assign busy            = busy_q;
  assign done            = done_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_kd_tree_query_scheduler.sv
// Directed bench for kd_tree_query_scheduler with a behavioural tree stub and
// a result scoreboard (expected {qid, leaf} queued at accept, checked at pop).
module tb_kd_tree_query_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_queries;
  logic        agg_full_n;
  logic        node_enq;
  logic        tree_fsm_enable;
  logic        patch_valid;
  logic        patch_ready;
  logic [54:0] patch_data;
  logic        tree_patch_en;
  logic [54:0] tree_patch_in;
  logic [7:0]  tree_leaf_index;
  logic        tree_leaf_valid;
  logic        result_valid;
  logic        result_ready;
  logic [7:0]  result_index;
  logic [3:0]  result_qid;
  logic        busy;
  logic        done;
  logic        proto_err;
`ifdef LATENCY_CHECK_EN
  logic        lat_err;
`endif

  kd_tree_query_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_queries(num_queries),
    .agg_full_n(agg_full_n), .node_enq(node_enq), .tree_fsm_enable(tree_fsm_enable),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_data(patch_data),
    .tree_patch_en(tree_patch_en), .tree_patch_in(tree_patch_in),
    .tree_leaf_index(tree_leaf_index), .tree_leaf_valid(tree_leaf_valid),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_index(result_index), .result_qid(result_qid),
    .busy(busy), .done(done),
`ifdef LATENCY_CHECK_EN
    .lat_err(lat_err),
`endif
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  int          pops = 0;
  int          stub_lat = 6;
  logic        spur = 1'b0;
  logic [3:0]  qid_m = '0;
  logic [7:0]  cur_leaf = '0;
  logic [11:0] exp_q [$];
  logic [54:0] patch_q [$];
  logic [7:0]  leaf_q [$];
  logic [15:0] vpipe = '0;
  logic [7:0]  ipipe [16];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mkp(input int a, input int b, input int c, input int d, input int e);
    return {11'(e), 11'(d), 11'(c), 11'(b), 11'(a)};
  endfunction

  // One clock: observe the DUT mid-cycle (accept, issue, pop), run the tree stub,
  // then return 1 time unit after the next rising edge for input driving.
  task automatic tick();
    logic [7:0]  lf;
    logic [11:0] e;
    lf = '0;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      vpipe = '0;
      tree_leaf_valid = 1'b0;
    end else begin
      if (tree_patch_en) begin
        chk("issue_pending", patch_q.size() != 0, 1);
        if (patch_q.size() != 0) begin
          chk("issue_patch", tree_patch_in, patch_q.pop_front());
          lf = leaf_q.pop_front();
        end
      end
      if (patch_valid && patch_ready) begin
        exp_q.push_back({qid_m, cur_leaf});
        patch_q.push_back(patch_data);
        leaf_q.push_back(cur_leaf);
        qid_m++;
        acc_cnt++;
        acc_cyc = cyc;
      end
      if (result_valid && result_ready) begin
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result_qid", result_qid, e[11:8]);
          chk("result_index", result_index, e[7:0]);
          pops++;
        end
      end
      for (int k = 15; k > 0; k--) ipipe[k] = ipipe[k-1];
      ipipe[0] = lf;
      vpipe = {vpipe[14:0], tree_patch_en};
      tree_leaf_valid = vpipe[stub_lat] | spur;
      tree_leaf_index = ipipe[stub_lat];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] nq, input bit gaps);
    int en_cnt;
    start = 1'b1; num_queries = nq; qid_m = '0;
    tick();
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_agg_full_n", agg_full_n, 1);
    en_cnt = 0;
    for (int i = 0; i < 63; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      node_enq = 1'b1;
      if (tree_fsm_enable) en_cnt++;
      tick();
      node_enq = 1'b0;
    end
    chk("load_en_cnt", en_cnt, 63);
    chk("load_end_fsm_en", tree_fsm_enable, 0);
    chk("load_end_agg", agg_full_n, 0);
    node_enq = 1'b1;
    chk("node64_blocked", agg_full_n, 0);
    tick();
    node_enq = 1'b0;
  endtask

  task automatic send(input logic [54:0] p, input logic [7:0] leaf);
    int n0, t;
    patch_data = p; cur_leaf = leaf; patch_valid = 1'b1;
    n0 = acc_cnt; t = 0;
    while (acc_cnt == n0 && t < 300) begin tick(); t++; end
    chk("send_accepted", acc_cnt, n0 + 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 300) begin tick(); t++; end
    chk("done_pulse", done, 1);
    chk("idle_at_done", busy, 0);
  endtask

  initial begin
    int n, p0, c0, c1, c2;
    rst_n = 1'b0; start = 1'b0; num_queries = '0; node_enq = 1'b0;
    patch_valid = 1'b0; patch_data = '0; result_ready = 1'b1;
    tree_leaf_valid = 1'b0; tree_leaf_index = '0;
    for (int k = 0; k < 16; k++) ipipe[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {agg_full_n, tree_fsm_enable, patch_ready, tree_patch_en, tree_patch_in,
                          result_valid, result_index, result_qid, busy, done, proto_err}, 0);
    rst_n = 1'b1;
    tick();

    // Load with gaps, then a single query; a stray start mid-pass is ignored.
    load(1, 1);
    start = 1'b1; num_queries = 16'd5; tick(); start = 1'b0;
    send(mkp(251, -26, -1, -88, 79), 8'd59);
    patch_valid = 1'b0;
    chk("single_issue_next_cycle", tree_patch_en, 1);
    n = 0;
    while (!result_valid && n < 50) begin tick(); n++; end
    // tree answers 6 cycles after issue; the result FIFO registers it once more
    chk("single_result_latency", n, 7);
    p0 = pops;
    wait_done();
    chk("single_pops", pops - p0, 1);

    // Three back-to-back patches.
    load(3, 0);
    p0 = pops;
    send(mkp(10, 20, 30, 40, 50), 8'd22);  c0 = acc_cyc;
    send(mkp(-5, 7, -9, 11, -13), 8'd5);   c1 = acc_cyc;
    send(mkp(1023, -1024, 0, 1, -1), 8'd60); c2 = acc_cyc;
    patch_valid = 1'b0;
    chk("b2b_accept_1", c1, c0 + 1);
    chk("b2b_accept_2", c2, c1 + 1);
    wait_done();
    chk("b2b_pops", pops - p0, 3);

    // Result backpressure: credits stop accepts at FIFO_DEPTH.
    result_ready = 1'b0;
    load(12, 0);
    p0 = pops; n = acc_cnt;
    for (int i = 0; i < 8; i++) send(mkp(i * 3, -i, i + 100, 7, -7), 8'(100 + i));
    patch_valid = 1'b0;
    repeat (20) tick();
    chk("bp_accepts", acc_cnt - n, 8);
    chk("bp_ready_low", patch_ready, 0);
    chk("bp_result_head", result_valid, 1);
    result_ready = 1'b1;
    for (int i = 8; i < 12; i++) send(mkp(i * 3, -i, i + 100, 7, -7), 8'(100 + i));
    patch_valid = 1'b0;
    wait_done();
    chk("bp_pops", pops - p0, 12);
    chk("bp_scoreboard_empty", exp_q.size(), 0);

    // Zero queries: load then straight to done with no accepts.
    patch_valid = 1'b1; patch_data = mkp(1, 2, 3, 4, 5); cur_leaf = 8'd1;
    n = acc_cnt;
    load(0, 0);
    wait_done();
    patch_valid = 1'b0;
    chk("zero_q_accepts", acc_cnt - n, 0);

`ifdef LATENCY_CHECK_EN
    chk("lat_err_clean", lat_err, 0);
    stub_lat = 7;
    load(1, 0);
    send(mkp(3, 3, 3, 3, 3), 8'd77);
    patch_valid = 1'b0;
    wait_done();
    chk("lat_err_set", lat_err, 1);
    stub_lat = 6;
`endif

    // Spurious leaf in IDLE.
    spur = 1'b1; tick(); spur = 1'b0; tick();
    chk("proto_err_set", proto_err, 1);
    chk("spurious_no_result", result_valid, 0);

    // Reset while a query is in flight.
    load(2, 0);
    send(mkp(9, 9, 9, 9, 9), 8'd9);
    patch_valid = 1'b0;
    tick(); tick();
    chk("mid_query_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {agg_full_n, tree_fsm_enable, patch_ready, tree_patch_en, tree_patch_in,
                              result_valid, result_index, result_qid, busy, done, proto_err}, 0);
`ifdef LATENCY_CHECK_EN
    chk("mid_reset_lat_err", lat_err, 0);
`endif
    exp_q.delete(); patch_q.delete(); leaf_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_reset_quiet", {busy, result_valid, proto_err}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
